seg7_scan_decoder: RTL

This block is the receive end of the multiplexed 4-digit seven-segment scan bus. It samples the `anodes`/`cathodes` scan lines and decodes each active-low segment pattern back to a hex nibble. It then reassembles the four digits into a 16-bit value and publishes one result per complete scan frame. It sits on the display bus of the guessing-game board, so game logic and the bench can read back what the display driver is actually showing.

---
 rtl/seg7_scan_decoder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Receive end of the multiplexed 4-digit seven-segment scan bus. Samples the
//   active-low anode/cathode scan lines, waits for each digit to be stable, decodes
//   the glyph back to a hex nibble and publishes one 16-bit value per complete
//   scan frame.
//
// Parameters
//   SETTLE      identical synchronized samples needed to accept a digit (>= 1)
//   TIMEOUT     clk cycles without a commit before stale asserts
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   anodes       [3:0] digit enables, active-low, asynchronous to clk
//   cathodes     [6:0] segments a..g active-low, bit 6 = a, bit 0 = g
//   value        [15:0] last committed frame, [15:12] = digit 3 .. [3:0] = digit 0
//   blank        [3:0] per-digit all-segments-off flag of the committed frame
//   seg_err      [3:0] per-digit illegal-glyph flag of the committed frame
//   frame_valid  one-cycle pulse on each commit
//   changed      one-cycle pulse with frame_valid when value differs from before
//   stale        no frame committed within TIMEOUT cycles
module seg7_scan_decoder #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  anodes,
    input  logic [6:0]  cathodes,
    output logic [15:0] value,
    output logic [3:0]  blank,
    output logic [3:0]  seg_err,
    output logic        frame_valid,
    output logic        changed,
    output logic        stale
);

    localparam int unsigned CW = (SETTLE  > 1) ? $clog2(SETTLE + 1) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT)    : 1;

    typedef enum logic {
        S_WAIT,
        S_HOLD
    } state_e;

    // Two-flop synchronizers; idle bus is all ones.
    logic [3:0]  an_s1_q, an_s2_q, an_prev_q;
    logic [6:0]  cat_s1_q, cat_s2_q, cat_prev_q;

    state_e      state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q;

    logic [15:0] sh_val_q;
    logic [3:0]  sh_blank_q, sh_err_q;
    logic [3:0]  seen_q, seen_d;

    logic [15:0] value_q;
    logic [3:0]  blank_q, seg_err_q;
    logic        frame_valid_q, changed_q, stale_q;

    logic        dig_valid;
    logic [1:0]  dig_idx;
    logic [3:0]  gl_nib;
    logic        gl_blank, gl_err;
    logic        same, an_chg, capture, commit, timeout_hit;

    assign value       = value_q;
    assign blank       = blank_q;
    assign seg_err     = seg_err_q;
    assign frame_valid = frame_valid_q;
    assign changed     = changed_q;
    assign stale       = stale_q;

    // Anode pattern -> digit index; anything but a single low line is no digit.
    always_comb begin
        dig_valid = 1'b1;
        dig_idx   = 2'd0;
        case (an_s2_q)
            4'b1110: dig_idx = 2'd3;
            4'b1101: dig_idx = 2'd2;
            4'b1011: dig_idx = 2'd1;
            4'b0111: dig_idx = 2'd0;
            default: dig_valid = 1'b0;
        endcase
    end

    // Glyph -> nibble. Blank and illegal patterns both decode to nibble 0.
    always_comb begin
        gl_nib   = 4'h0;
        gl_blank = 1'b0;
        gl_err   = 1'b0;
        case (cat_s2_q)
            7'b0000001: gl_nib = 4'h0;
            7'b1001111: gl_nib = 4'h1;
            7'b0010010: gl_nib = 4'h2;
            7'b0000110: gl_nib = 4'h3;
            7'b1001100: gl_nib = 4'h4;
            7'b0100100: gl_nib = 4'h5;
            7'b0100000: gl_nib = 4'h6;
            7'b0001111: gl_nib = 4'h7;
            7'b0000000: gl_nib = 4'h8;
            7'b0000100: gl_nib = 4'h9;
            7'b0001000: gl_nib = 4'hA;
            7'b1100000: gl_nib = 4'hB;
            7'b0110001: gl_nib = 4'hC;
            7'b1000010: gl_nib = 4'hD;
            7'b0110000: gl_nib = 4'hE;
            7'b0111000: gl_nib = 4'hF;
            7'b1111111: gl_blank = 1'b1;
            default:    gl_err   = 1'b1;
        endcase
    end

    // cnt_d is the number of identical samples seen so far, minus one. The sample
    // that first shows a new pattern counts as sample 1 (cnt_d = 0), so with
    // SETTLE = 1 a digit is captured on the very first sample, even out of HOLD.
    always_comb begin
        same        = ({an_s2_q, cat_s2_q} == {an_prev_q, cat_prev_q});
        an_chg      = (an_s2_q != an_prev_q);
        cnt_d       = (dig_valid && same) ? cnt_q + CW'(1) : '0;
        capture     = dig_valid && (cnt_d == CW'(SETTLE - 1)) &&
                      ((state_q == S_WAIT) || an_chg);
        commit      = (seen_q == 4'b1111);
        timeout_hit = !commit && (tcnt_q == TW'(TIMEOUT - 1));

        seen_d = (commit || timeout_hit) ? 4'b0000 : seen_q;
        if (capture) begin
            seen_d[dig_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1_q       <= '1;
            an_s2_q       <= '1;
            an_prev_q     <= '1;
            cat_s1_q      <= '1;
            cat_s2_q      <= '1;
            cat_prev_q    <= '1;
            state_q       <= S_WAIT;
            cnt_q         <= '0;
            tcnt_q        <= '0;
            sh_val_q      <= '0;
            sh_blank_q    <= '0;
            sh_err_q      <= '0;
            seen_q        <= '0;
            value_q       <= '0;
            blank_q       <= '0;
            seg_err_q     <= '0;
            frame_valid_q <= 1'b0;
            changed_q     <= 1'b0;
            stale_q       <= 1'b1;
        end else begin
            an_s1_q    <= anodes;
            an_s2_q    <= an_s1_q;
            cat_s1_q   <= cathodes;
            cat_s2_q   <= cat_s1_q;
            an_prev_q  <= an_s2_q;
            cat_prev_q <= cat_s2_q;

            // Scan FSM: HOLD ignores cathode-only changes and parks the counter.
            if (capture) begin
                state_q <= S_HOLD;
            end else if ((state_q == S_HOLD) && an_chg) begin
                state_q <= S_WAIT;
            end
            cnt_q <= ((state_q == S_HOLD) && !an_chg) ? '0 : cnt_d;

            if (capture) begin
                sh_val_q[dig_idx*4 +: 4] <= gl_nib;
                sh_blank_q[dig_idx]      <= gl_blank;
                sh_err_q[dig_idx]        <= gl_err;
            end
            seen_q <= seen_d;

            // Commit reads the shadow before any same-cycle capture lands in it.
            frame_valid_q <= commit;
            changed_q     <= commit && (sh_val_q != value_q);
            if (commit) begin
                value_q   <= sh_val_q;
                blank_q   <= sh_blank_q;
                seg_err_q <= sh_err_q;
            end

            if (commit) begin
                stale_q <= 1'b0;
                tcnt_q  <= '0;
            end else if (timeout_hit) begin
                stale_q <= 1'b1;
                tcnt_q  <= '0;
            end else begin
                tcnt_q  <= tcnt_q + TW'(1);
            end
        end
    end

endmodule
